// File: rtl/mux_scan_n.sv
// Registered N-channel by W-bit multiplexer with manual select, round-robin
// scan with per-channel dwell, hold, and a sample-valid strobe.
module mux_scan_n #(
  parameter  int W     = 4,
  parameter  int N     = 4,
  parameter  int DWELL = 8,
  localparam int SW    = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N*W-1:0]   D,
  input  logic [SW-1:0]    SEL,
  input  logic             MODE,
  input  logic             E,
  input  logic             HOLD,
  output logic [W-1:0]     Y,
  output logic [SW-1:0]    Y_CH,
  output logic             Y_VALID,
  output logic             SEL_ERR
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
  localparam logic [DW-1:0] LAST_DW = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_MANUAL,
    ST_SCAN
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   chan_q, chan_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [W-1:0]    y_q, y_d;
  logic [SW-1:0]   y_ch_q, y_ch_d;
  logic            y_valid_q, y_valid_d;
  logic            sel_err_q, sel_err_d;

  logic [SW-1:0]   chan_cur;
  logic [DW-1:0]   dwell_cur;
  logic [W-1:0]    ch_data [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch_data[k] = D[k*W +: W];
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    dwell_d   = dwell_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    sel_err_d = sel_err_q;
    // Entering scan from any other state restarts the rotation at channel 0.
    chan_cur  = (state_q == ST_SCAN) ? chan_q  : '0;
    dwell_cur = (state_q == ST_SCAN) ? dwell_q : '0;

    if (E) begin
      state_d   = ST_DISABLED;
      chan_d    = '0;
      dwell_d   = '0;
      y_d       = '0;
      y_ch_d    = '0;
      sel_err_d = 1'b0;
    end else if (HOLD) begin
      state_d = state_q;
    end else if (!MODE) begin
      state_d = ST_MANUAL;
      chan_d  = '0;
      dwell_d = '0;
      if (int'(SEL) < N) begin
        y_d       = ch_data[SEL];
        y_ch_d    = SEL;
        y_valid_d = 1'b1;
        sel_err_d = 1'b0;
      end else begin
        sel_err_d = 1'b1;
      end
    end else begin
      state_d   = ST_SCAN;
      sel_err_d = 1'b0;
      if (dwell_cur == '0) begin
        y_d       = ch_data[chan_cur];
        y_ch_d    = chan_cur;
        y_valid_d = 1'b1;
      end
      if (dwell_cur == LAST_DW) begin
        dwell_d = '0;
        chan_d  = (chan_cur == LAST_CH) ? '0 : chan_cur + 1'b1;
      end else begin
        dwell_d = dwell_cur + 1'b1;
        chan_d  = chan_cur;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_DISABLED;
      chan_q    <= '0;
      dwell_q   <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      dwell_q   <= dwell_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign Y       = y_q;
  assign Y_CH    = y_ch_q;
  assign Y_VALID = y_valid_q;
  assign SEL_ERR = sel_err_q;

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-channel by W-bit multiplexer. It generalises the team's quad 2-to-1 active-low-enable mux to arbitrary channel count and width. It adds a manual-select mode and an automatic round-robin scan mode with a per-channel dwell counter, a hold input, and a sample-valid strobe. It sits between parallel data sources and a single downstream consumer (display driver, serial framer) that must see one channel at a time.

## Interface
Parameters:
- W, 4, data width per channel (>= 1)
- N, 4, channel count (>= 2)
- DWELL, 8, cycles spent on each channel in scan mode (>= 1)
- SW (derived, not overridable), clog2(N), select/index width

Ports:
- CLK  in  1  clock; all registers update on the rising edge
- RST  in  1  asynchronous, active-high reset
- D  in  N*W  channel data; channel k = D[k*W +: W]
- SEL  in  SW  channel select; used in manual mode only
- MODE  in  1  0 = manual, 1 = scan
- E  in  1  active-low enable; E=1 disables the block
- HOLD  in  1  freezes all state while enabled
- Y  out  W  registered selected data
- Y_CH  out  SW  index of the channel currently in Y
- Y_VALID  out  1  one-cycle strobe: Y holds a new sample
- SEL_ERR  out  1  manual SEL out of range (SEL >= N)

## Operation
- Internal state: DISABLED, MANUAL, SCAN. The next state is chosen every cycle: E=1 gives DISABLED; otherwise MODE=0 gives MANUAL and MODE=1 gives SCAN.
- Internal counters: chan (SW bits, 0..N-1) and dwell (0..DWELL-1).
- Priority: RST > E > HOLD > MODE.
- DISABLED (E=1), per edge:
  - Y=0, Y_CH=0, Y_VALID=0, SEL_ERR=0.
  - chan=0, dwell=0.
  - SEL, MODE and HOLD are ignored.
- HOLD=1 with E=0:
  - Y, Y_CH, SEL_ERR, chan, dwell and state all hold.
  - Y_VALID=0.
- MANUAL, per non-held edge:
  - If SEL < N: Y=D[SEL], Y_CH=SEL, Y_VALID=1, SEL_ERR=0. Y_VALID stays high every cycle while in MANUAL.
  - If SEL >= N (possible only when N is not a power of 2): Y and Y_CH hold, Y_VALID=0, SEL_ERR=1.
  - chan and dwell are held at 0.
- SCAN, per non-held edge:
  - When dwell==0: Y=D[chan], Y_CH=chan, Y_VALID=1.
  - Otherwise: Y and Y_CH hold (sample-and-hold), Y_VALID=0.
  - dwell increments. At DWELL-1 it wraps to 0 and chan increments.
  - chan wraps from N-1 to 0.
  - SEL_ERR=0. SEL is ignored.
- Scan entry from MANUAL or DISABLED always starts with chan=0, dwell=0. The first capture happens on the first SCAN edge.
- A MODE change mid-dwell takes effect on the next edge. Scan progress is discarded, not resumed.
- DWELL=1: capture and channel advance happen on every edge, so Y_VALID is continuously high.

## Timing
- Reset values: Y=0, Y_CH=0, Y_VALID=0, SEL_ERR=0, state DISABLED, chan=0, dwell=0. Outputs clear asynchronously on RST assertion. The first update occurs on the first rising edge after RST deasserts.
- RST asserted mid-scan or mid-hold clears everything. Scan restarts at channel 0.
- Manual latency: 1 cycle from SEL/D change to Y.
- Scan period: Y_VALID pulses every DWELL cycles. A full rotation takes N*DWELL cycles. D is sampled only on pulse edges.
- E is sampled synchronously. Disable takes effect at the next edge, not combinationally.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset: assert RST mid-scan (chan=2) -> Y, Y_CH, Y_VALID, SEL_ERR all 0 before the next edge. Release RST with E=0, MODE=1 -> first pulse has Y_CH=0.
- Manual (W=4, N=4, D ch0..3 = 0x1,0x2,0x3,0x4): SEL=2 -> next edge Y=0x3, Y_CH=2, Y_VALID=1. Then SEL=0 -> next edge Y=0x1.
- Disable: MODE=0, SEL=3, then E=1 -> next edge Y=0, Y_VALID=0. Set E=0 -> next edge Y=0x4.
- Scan (N=4, DWELL=3, MODE=1 from the cycle-0 edge): Y_VALID high on edges 0,3,6,9,12 with Y_CH 0,1,2,3,0 and Y=0x1,0x2,0x3,0x4,0x1. Y_VALID is low on all other edges.
- Hold: same setup, HOLD=1 on edges 4-5 -> Y_VALID=0 and Y=0x2 held. Subsequent pulses land on edges 8 and 11 with Y_CH 2 and 3.
- Range error (N=3, SW=2): MODE=0, SEL=3 after a valid SEL=1 -> SEL_ERR=1, Y_VALID=0, Y and Y_CH hold ch1 values. SEL=2 -> SEL_ERR=0, Y=D ch2.
